// File: rtl/spi_slave_ctrl.sv
// SPI slave front end for a single-port RAM: assembles W-bit command words from MOSI
// and serialises RAM read data back out on MISO.
`timescale 1ns/1ps
module spi_slave_ctrl #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);

  localparam int W  = ADDR_SIZE + 2;
  localparam int CW = $clog2(W + 1);
  localparam int TW = $clog2(ADDR_SIZE + 1);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  state_t                state, state_next;
  logic [W-1:0]          shift_reg;
  logic [W-1:0]          word_next;
  logic [CW-1:0]         bit_cnt;
  logic                  last_bit;
  logic                  word_done;
  logic                  tx_wait;
  logic                  rd_addr_seen;
  logic [ADDR_SIZE-1:0]  tx_shift;
  logic [TW-1:0]         tx_cnt;

  assign word_next = {shift_reg[W-2:0], MOSI};
  assign last_bit  = (bit_cnt == CW'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!SS_n) state_next = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)              state_next = IDLE;
        else if (!MOSI)        state_next = WRITE;
        else if (rd_addr_seen) state_next = READ_DATA;
        else                   state_next = READ_ADD;
      end
      default: if (SS_n) state_next = IDLE;
    endcase
  end

  // Once a word is complete the frame only services the read-data return path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg    <= '0;
      bit_cnt      <= '0;
      word_done    <= 1'b0;
      tx_wait      <= 1'b0;
      tx_shift     <= '0;
      tx_cnt       <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_seen <= 1'b0;
      MISO         <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state != IDLE && SS_n) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
        word_done <= 1'b0;
        tx_wait   <= 1'b0;
        tx_shift  <= '0;
        tx_cnt    <= '0;
        MISO      <= 1'b0;
      end else begin
        case (state)
          IDLE: MISO <= 1'b0;
          CHK_CMD: begin
            shift_reg <= word_next;
            bit_cnt   <= CW'(1);
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (!word_done) begin
              shift_reg <= word_next;
              bit_cnt   <= bit_cnt + 1'b1;
              if (last_bit) begin
                rx_data   <= word_next;
                rx_valid  <= 1'b1;
                word_done <= 1'b1;
                if (state == READ_ADD) rd_addr_seen <= 1'b1;
                if (state == READ_DATA) begin
                  rd_addr_seen <= 1'b0;
                  tx_wait      <= 1'b1;
                end
              end
            end else if (tx_wait && tx_valid) begin
              tx_shift <= tx_data;
              tx_cnt   <= TW'(ADDR_SIZE);
              tx_wait  <= 1'b0;
            end else if (tx_cnt != '0) begin
              MISO     <= tx_shift[ADDR_SIZE-1];
              tx_shift <= {tx_shift[ADDR_SIZE-2:0], 1'b0};
              tx_cnt   <= tx_cnt - 1'b1;
            end else begin
              MISO <= 1'b0;
            end
          end
          default: MISO <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Scoreboard bench for spi_slave_ctrl: directed frames push expected words and MISO bits,
// a monitor pops and compares whenever the DUT presents rx_valid or serial read data.
`timescale 1ns/1ps
module tb_spi_slave_ctrl;

  localparam int ADDR_SIZE = 8;
  localparam int W = ADDR_SIZE + 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 SS_n;
  logic                 MOSI;
  logic                 MISO;
  logic [W-1:0]         rx_data;
  logic                 rx_valid;
  logic [ADDR_SIZE-1:0] tx_data;
  logic                 tx_valid;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_miso_q[$];
  int           miso_cnt = 0;

  logic [7:0] mem [256];
  logic [7:0] addr_reg = 8'h00;
  logic [7:0] rd_addr  = 8'h00;

  always #5 clk = ~clk;

  spi_slave_ctrl #(.ADDR_SIZE(ADDR_SIZE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: pops expected words on rx_valid and expected bits while MISO is shifting.
  always @(posedge clk) begin
    logic [W-1:0] exp_word;
    logic         exp_bit;
    #2;
    if (rx_valid) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_rx_valid", 32'(rx_valid), 32'd0);
      end else begin
        exp_word = exp_q.pop_front();
        check_output("rx_data", 32'(rx_data), 32'(exp_word));
        case (rx_data[W-1:W-2])
          2'b00:   addr_reg = rx_data[7:0];
          2'b01:   mem[addr_reg] = rx_data[7:0];
          2'b10:   rd_addr = rx_data[7:0];
          default: ;
        endcase
      end
    end
    if (miso_cnt > 0) begin
      exp_bit = exp_miso_q.pop_front();
      check_output("miso_bit", 32'(MISO), 32'(exp_bit));
      miso_cnt--;
    end else begin
      check_output("miso_idle", 32'(MISO), 32'd0);
      if (tx_valid && exp_miso_q.size() > 0) miso_cnt = exp_miso_q.size();
    end
  end

  // Drives one frame from a negedge; abort_on_last raises SS_n together with the final bit.
  task automatic apply_stimulus(input logic [W-1:0] word, input int nbits, input bit abort_on_last);
    if (nbits == W && !abort_on_last) exp_q.push_back(word);
    @(negedge clk);
    SS_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      MOSI = word[W-1-i];
      if (abort_on_last && i == nbits - 1) SS_n = 1'b1;
    end
    @(negedge clk);
    if (nbits == W) check_output("rx_valid_latency", 32'(rx_valid), 32'(!abort_on_last));
  endtask

  task automatic end_frame();
    SS_n = 1'b1;
    MOSI = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_tx(input logic [7:0] data, input logic [7:0] exp_bits, input bit accept);
    tx_data  = data;
    tx_valid = 1'b1;
    if (accept) for (int i = 7; i >= 0; i--) exp_miso_q.push_back(exp_bits[i]);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (2) @(negedge clk);
    check_output("reset_rx_data", 32'(rx_data), 32'd0);
    check_output("reset_rx_valid", 32'(rx_valid), 32'd0);
    check_output("reset_miso", 32'(MISO), 32'd0);
    check_output("reset_rd_addr_seen", 32'(dut.rd_addr_seen), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write address, write data, then read address / read data round trip.
    apply_stimulus(10'b00_1010_0101, W, 1'b0);
    end_frame();
    apply_stimulus(10'b01_0011_1100, W, 1'b0);
    end_frame();
    check_output("ram_model_a5", 32'(mem[8'hA5]), 32'h3C);
    apply_stimulus(10'b10_1010_0101, W, 1'b0);
    check_output("rd_addr_seen_set", 32'(dut.rd_addr_seen), 32'd1);
    end_frame();
    apply_stimulus(10'b11_0000_0000, W, 1'b0);
    send_tx(mem[rd_addr], 8'h3C, 1'b1);
    repeat (10) @(negedge clk);
    send_tx(8'hFF, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    check_output("rd_addr_seen_clear", 32'(dut.rd_addr_seen), 32'd0);
    end_frame();

    // Aborted frames leave rx_data untouched; the next full frame still decodes.
    apply_stimulus(10'b00_1100_0011, 6, 1'b0);
    end_frame();
    apply_stimulus(10'b00_1100_0011, W, 1'b1);
    end_frame();
    check_output("rx_data_hold", 32'(rx_data), 32'h300);
    apply_stimulus(10'b00_1100_0011, W, 1'b0);
    end_frame();

    // After reset a read-data command lands in READ_ADD, so tx_valid is ignored.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus(10'b11_0000_0000, W, 1'b0);
    check_output("read_add_after_reset", 32'(dut.rd_addr_seen), 32'd1);
    send_tx(8'h5A, 8'h00, 1'b0);
    repeat (10) @(negedge clk);
    end_frame();

    // Asynchronous reset between edges while MISO is shifting 0xA5.
    apply_stimulus(10'b11_0101_0101, W, 1'b0);
    send_tx(8'hA5, 8'hA5, 1'b1);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_output("async_reset_miso", 32'(MISO), 32'd0);
    check_output("async_reset_rx_data", 32'(rx_data), 32'd0);
    check_output("async_reset_rd_addr_seen", 32'(dut.rd_addr_seen), 32'd0);
    exp_miso_q.delete();
    miso_cnt = 0;
    SS_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    apply_stimulus(10'b00_1111_0000, W, 1'b0);
    end_frame();

    check_output("rx_words_outstanding", 32'(exp_q.size()), 32'd0);
    check_output("miso_bits_outstanding", 32'(exp_miso_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
